// File: rtl/wshb_pkg.sv
// Shared Wishbone encodings and the RAM-slave state type.
package wshb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00
  } bte_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    ERR
  } slv_state_t;

endpackage

// File: rtl/wshb_ram_bytewe.sv
// Single-port synchronous RAM with per-byte write enables and a registered,
// enable-gated read port whose register is cleared by reset.
module wshb_ram_bytewe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic                    re,
  input  logic [DATA_W/8-1:0]     we,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/wshb_ram_slave.sv
// Wishbone B4 classic / incrementing-burst slave backed by on-chip RAM,
// with programmable wait states and err termination for bad addresses.
module wshb_ram_slave
  import wshb_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADR_W       = 32,
  parameter int unsigned DEPTH_LOG2  = 12,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cyc,
  input  logic                  stb,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   sel,
  input  logic [ADR_W-1:0]      adr,
  input  logic [2:0]            cti,
  input  logic [1:0]            bte,
  input  logic [DATA_W-1:0]     dat_ms,
  output logic [DATA_W-1:0]     dat_sm,
  output logic                  ack,
  output logic                  err
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(SEL_W);
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = 4;

  slv_state_t        state, nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [AW-1:0]     addr_q, addr_nxt;
  logic              we_q, we_nxt;

  logic              live_c, bad_c, incr_c;
  logic [AW-1:0]     bus_idx_c;
  logic [AW-1:0]     ram_addr_c;
  logic              ram_re_c;
  logic [SEL_W-1:0]  ram_we_c;
  logic              unused_c;

  assign live_c    = cyc & stb;
  assign incr_c    = (cti == CTI_INCR);
  assign bus_idx_c = AW'(adr >> OFS);
  assign bad_c     = ((adr >> (AW + OFS)) != '0) || ((adr & ADR_W'(SEL_W - 1)) != '0);
  // bte is accepted but every burst is handled as linear
  assign unused_c  = ^bte;

  always_comb begin
    nxt        = state;
    cnt_nxt    = cnt;
    addr_nxt   = addr_q;
    we_nxt     = we_q;
    ram_re_c   = 1'b0;
    ram_addr_c = addr_q;
    ram_we_c   = '0;
    case (state)
      IDLE: begin
        if (live_c) begin
          addr_nxt = bus_idx_c;
          we_nxt   = we;
          if (bad_c)                 nxt = ERR;
          else if (WAIT_STATES == 0) nxt = ACK;
          else begin
            nxt     = WAIT;
            cnt_nxt = CW'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (!live_c) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else if (cnt == '0) begin
          nxt = ACK;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ACK: begin
        if (live_c && we_q) ram_we_c = sel;
        if (live_c && incr_c) begin
          if (addr_q == '1) nxt = ERR;
          else begin
            nxt      = ACK;
            addr_nxt = addr_q + AW'(1);
          end
        end else begin
          nxt = IDLE;
        end
      end
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // read port fetches the word of the beat about to be acknowledged
    if (nxt == ACK && !we_nxt) begin
      ram_re_c   = 1'b1;
      ram_addr_c = addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      we_q   <= we_nxt;
      ack    <= (nxt == ACK);
      err    <= (nxt == ERR);
    end
  end

  wshb_ram_bytewe #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .addr (ram_addr_c),
    .re   (ram_re_c),
    .we   (ram_we_c),
    .wdata(dat_ms),
    .rdata(dat_sm)
  );

endmodule

// File: tb/tb_wshb_ram_slave.sv
// Directed bench for wshb_ram_slave: classic, byte-lane, burst, error,
// abort and mid-burst reset cases with hand-computed expectations.
module tb_wshb_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] adr = '0;
  logic [2:0]  cti = 3'b000;
  logic [1:0]  bte = 2'b00;
  logic [15:0] dat_ms = '0;
  logic [15:0] dat_sm;
  logic        ack;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wshb_ram_slave #(
    .DATA_W     (16),
    .ADR_W      (32),
    .DEPTH_LOG2 (12),
    .WAIT_STATES(2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .cyc   (cyc),
    .stb   (stb),
    .we    (we),
    .sel   (sel),
    .adr   (adr),
    .cti   (cti),
    .bte   (bte),
    .dat_ms(dat_ms),
    .dat_sm(dat_sm),
    .ack   (ack),
    .err   (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic w, input logic [31:0] a, input logic [15:0] d,
                       input logic [1:0] s, input logic [2:0] c);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_ms = d; sel = s; cti = c;
  endtask

  task automatic stop_bus();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  task automatic wait_term(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!ack && !err && lat < 20);
    if (!ack && !err) chk("term_timeout", 32'(ack | err), 32'd1);
  endtask

  // classic transfer; master holds the request through the terminating edge
  task automatic single(input logic w, input logic [31:0] a, input logic [15:0] d,
                        input logic [1:0] s, output int lat, output logic [15:0] rd,
                        output logic ak, output logic e, output logic tail);
    start(w, a, d, s, 3'b000);
    wait_term(lat);
    rd = dat_sm;
    ak = ack;
    e  = err;
    tick();
    tail = ack | err;
    stop_bus();
  endtask

  task automatic burst(input logic w, input logic [31:0] a, input logic [15:0] base);
    int lat;
    start(w, a, base, 2'b11, 3'b010);
    wait_term(lat);
    chk("burst_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      dat_ms = base + 16'(i);
      cti    = (i == 3) ? 3'b111 : 3'b010;
      chk($sformatf("burst_ack%0d", i), 32'(ack), 32'd1);
      if (!w) chk($sformatf("burst_rd%0d", i), 32'(dat_sm), 32'(base + 16'(i)));
      tick();
    end
    chk("burst_end", 32'(ack), 32'd0);
    stop_bus();
    tick();
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic        ak, e, tail, seen;

    repeat (3) tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dat", 32'(dat_sm), 32'd0);
    rst = 1'b1;
    tick();

    single(1'b1, 32'h10, 16'hBEEF, 2'b11, lat, rd, ak, e, tail);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_ack", 32'(ak), 32'd1);
    chk("wr_tail", 32'(tail), 32'd0);
    single(1'b0, 32'h10, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", 32'(rd), 32'hBEEF);

    single(1'b1, 32'h20, 16'h1234, 2'b11, lat, rd, ak, e, tail);
    single(1'b1, 32'h20, 16'hAB00, 2'b10, lat, rd, ak, e, tail);
    single(1'b0, 32'h20, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("lane_data", 32'(rd), 32'hAB34);

    burst(1'b1, 32'h100, 16'd1);
    burst(1'b0, 32'h100, 16'd1);

    single(1'b0, 32'h2000, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("oor_err", 32'(e), 32'd1);
    chk("oor_ack", 32'(ak), 32'd0);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_dat", 32'(rd), 32'd4);
    chk("oor_tail", 32'(tail), 32'd0);

    single(1'b1, 32'h0, 16'h0A0A, 2'b11, lat, rd, ak, e, tail);
    single(1'b1, 32'h1, 16'hFFFF, 2'b11, lat, rd, ak, e, tail);
    chk("odd_err", 32'(e), 32'd1);
    chk("odd_ack", 32'(ak), 32'd0);
    single(1'b0, 32'h0, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("odd_ram", 32'(rd), 32'h0A0A);

    single(1'b1, 32'h30, 16'h1111, 2'b11, lat, rd, ak, e, tail);
    start(1'b1, 32'h30, 16'h5555, 2'b11, 3'b000);
    tick();
    chk("abort_wait", 32'(ack | err), 32'd0);
    stop_bus();
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen = seen | ack | err;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    single(1'b0, 32'h30, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("abort_ram", 32'(rd), 32'h1111);

    start(1'b1, 32'h200, 16'h00A1, 2'b11, 3'b010);
    wait_term(lat);
    tick();
    dat_ms = 16'h00A2;
    chk("mid_ack", 32'(ack), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_dat", 32'(dat_sm), 32'd0);
    stop_bus();
    tick();
    tick();
    rst = 1'b1;
    tick();
    single(1'b0, 32'h200, 16'h0, 2'b11, lat, rd, ak, e, tail);
    chk("mid_beat1", 32'(rd), 32'h00A1);
    chk("mid_beat1_ack", 32'(ak), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wshb_ram_slave.md
Name: wshb_ram_slave

Overview:
Wishbone B4 classic/registered-feedback slave (responder) backed by on-chip RAM. It sits on the far side of a Wishbone master port, either as a stand-in for the SDRAM controller in simulation and FPGA bring-up, or as a small frame/line store. It serves single reads and writes plus incrementing bursts, with programmable wait states and an error response for out-of-range addresses.

Parameters:
DATA_W, 16, data bus width in bits; SEL_W = DATA_W/8.
ADR_W, 32, byte-address width of the bus.
DEPTH_LOG2, 12, log2 of the number of RAM words.
WAIT_STATES, 2, cycles inserted between stb sampled and the first ack (0..15).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-low reset.
cyc  in  1  bus cycle valid.
stb  in  1  strobe / transfer request.
we  in  1  1 = write, 0 = read.
sel  in  SEL_W  byte-lane enables.
adr  in  ADR_W  byte address; word index = adr[DEPTH_LOG2:1] for DATA_W = 16.
cti  in  3  000 classic, 010 incrementing burst, 111 end of burst.
bte  in  2  burst type extension; only 00 (linear) is supported.
dat_ms  in  DATA_W  write data, master to slave.
dat_sm  out  DATA_W  read data, slave to master.
ack  out  1  normal termination.
err  out  1  error termination.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; ack = 0, err = 0, dat_sm = 0; wait counter = 0. RAM contents are not cleared.
- States: IDLE, WAIT, ACK, ERR.
- IDLE, on cyc & stb sampled high:
  - Latch word address, we, sel and cti.
  - Out of range (any of adr[ADR_W-1:DEPTH_LOG2+1] set, or adr[0] set): go to ERR.
  - Else if WAIT_STATES = 0: go to ACK.
  - Else: go to WAIT with counter = WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; go to ACK when it reaches 0.
  - cyc or stb low: abort to IDLE, no write, no ack.
- ACK:
  - ack = 1 for exactly this cycle, unless extended by a burst.
  - Write: during the ack cycle, the RAM is written with dat_ms at the latched address, each byte lane gated by sel.
  - Read: dat_sm holds RAM[latched address] and is valid while ack = 1.
  - First-beat latency is WAIT_STATES+1 cycles from the cycle stb is first sampled.
- ERR: err = 1 for one cycle, ack = 0, no RAM write, dat_sm unchanged; then go to IDLE.
- Burst continuation, evaluated in the ACK cycle:
  - If cyc & stb & cti = 010 & bte = 00: stay in ACK, internal word address +1, ack stays high (one beat per cycle, no further wait states).
  - Write beats take dat_ms/sel from each new cycle; read beats present the incremented address's data.
  - Burst address crossing the top of RAM (index 2^DEPTH_LOG2-1 to 0): next beat terminates with err instead; go to ERR.
  - cti = 111 or 000 in the ACK cycle: that beat is the last one; go to IDLE, ack low next cycle.
  - bte != 00 with cti = 010: treated as linear.
- cyc low in any state: go to IDLE on the next edge. ack and err are never asserted while cyc is low.
- ack and err are never high together.
- dat_sm changes only when a read beat is acknowledged; it holds its value otherwise.
- Back-to-back: after returning to IDLE, a new stb is accepted on the following cycle, so there is at least one idle cycle between classic transfers.

Decomposition:
- Package wshb_pkg holds:
  - Enum cti_t (CTI_CLASSIC = 3'b000, CTI_INCR = 3'b010, CTI_EOB = 3'b111).
  - Enum bte_t (BTE_LINEAR = 2'b00).
  - State enum slv_state_t {IDLE, WAIT, ACK, ERR}.
- Sub-module wshb_ram_bytewe: single-port synchronous RAM, DATA_W wide, with per-byte write enable and registered read. It is instantiated once.

Test Plan:
- Classic write then read, WAIT_STATES = 2:
  - Write adr 0x0010, dat 0xBEEF, sel 11: ack rises on the 3rd cycle after stb.
  - Read adr 0x0010: dat_sm = 0xBEEF with ack.
- Byte lanes:
  - Write 0x1234 to 0x0020 (sel 11), then 0xAB00 with sel 10.
  - Read 0x0020: 0xAB34.
- Incrementing burst, 4 writes from adr 0x0100 with data 1, 2, 3, 4 (cti 010, 010, 010, 111):
  - ack high for 4 consecutive cycles, then low.
  - Burst read of the same range returns 1, 2, 3, 4 on consecutive ack cycles.
- Out-of-range, DEPTH_LOG2 = 12:
  - Read adr 0x0000_2000: err pulses for 1 cycle, ack stays 0.
  - Write adr 0x0001 (odd): err pulses; RAM is unchanged.
- Abort:
  - Drop cyc during WAIT of a write to 0x0030 (data 0x5555): no ack, no err.
  - Later read of 0x0030 returns the prior value.
- Reset mid-burst:
  - Assert rst = 0 during beat 2: ack, err and dat_sm go to 0 immediately (asynchronous).
  - After release, a classic read of beat-1's address returns beat-1 data.
